// File: rtl/apb_rr_master_arbiter.sv
// Round-robin APB master: shares one APB bus between NUM_REQ requesters, runs
// SETUP/ACCESS with an optional ACCESS timeout and returns a tagged response.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET_N,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic                       PSEL_M_INF,
    output logic                       PENABLE_M_INF,
    output logic                       PWRITE_M_INF,
    output logic [ADDR_W-1:0]          PADDR_M_INF,
    output logic [DATA_W-1:0]          PWDATA_M_INF,
    input  logic                       PREADY_S_INF,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PSLVERR_S_INF
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  wait_cnt;

    logic [ID_W-1:0]   grant_id_p0;
    logic              write_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              timeout_hit;
    logic              xfer_done;
    logic              arb_slot;
    logic              accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Rotating priority search starting just after the last granted requester.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // PREADY takes precedence: a timeout only fires while the slave is still stalling.
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_ACCESS) && !PREADY_S_INF
                         && (wait_cnt == CNT_LAST);
    assign xfer_done   = (state == ST_ACCESS) && (PREADY_S_INF || timeout_hit);
    assign arb_slot    = PRESET_N && ((state == ST_IDLE) || xfer_done);
    assign accept      = arb_slot && win_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (win_id == ID_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (xfer_done) state_nxt = accept ? ST_SETUP : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) last_grant <= win_id;
            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ST_ACCESS) && !PREADY_S_INF) begin
                wait_cnt <= sat_inc(wait_cnt);
            end
        end
    end

    // Stage p0: requester fields latched in the accept cycle, owned by the bus afterwards.
    always_ff @(posedge PCLK) begin
        if (accept) begin
            grant_id_p0 <= win_id;
            write_p0    <= sel_write;
            addr_p0     <= sel_addr;
            wdata_p0    <= sel_wdata;
        end
    end

    // Response stage: loads in the completion cycle, fields hold until the next response.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= xfer_done;
            if (xfer_done) begin
                rsp_id      <= grant_id_p0;
                rsp_rdata   <= (!write_p0 && !timeout_hit) ? PRDATA : '0;
                rsp_err     <= PSLVERR_S_INF | timeout_hit;
                rsp_timeout <= timeout_hit;
            end
        end
    end

    assign PSEL_M_INF    = (state != ST_IDLE);
    assign PENABLE_M_INF = (state == ST_ACCESS);
    assign PWRITE_M_INF  = PSEL_M_INF && write_p0;
    assign PADDR_M_INF   = PSEL_M_INF ? addr_p0 : '0;
    assign PWDATA_M_INF  = (PSEL_M_INF && write_p0) ? wdata_p0 : '0;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed scenarios plus a randomized run
// against a transaction-timeline model of the arbiter and APB sequence.
module tb_apb_rr_master_arbiter;

    localparam int NR = 4;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESET_N;
    logic [3:0]    req_valid;
    logic [3:0]    req_write;
    logic [127:0]  req_addr;
    logic [127:0]  req_wdata;
    logic [3:0]    req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF;
    logic [31:0]   PADDR_M_INF;
    logic [31:0]   PWDATA_M_INF;
    logic          PREADY_S_INF;
    logic [31:0]   PRDATA;
    logic          PSLVERR_S_INF;

    int checks = 0;
    int errors = 0;

    logic          pv[4];
    logic          pw[4];
    logic [31:0]   pa[4];
    logic [31:0]   pd[4];

    apb_rr_master_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL_M_INF(PSEL_M_INF), .PENABLE_M_INF(PENABLE_M_INF), .PWRITE_M_INF(PWRITE_M_INF),
        .PADDR_M_INF(PADDR_M_INF), .PWDATA_M_INF(PWDATA_M_INF),
        .PREADY_S_INF(PREADY_S_INF), .PRDATA(PRDATA), .PSLVERR_S_INF(PSLVERR_S_INF)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic nc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            nc();
            req_valid    = '0;
            PREADY_S_INF = 1'b1;
        end
    endtask

    task automatic test_reset();
        PRESET_N = 1'b0;
        req_valid = 4'b1111; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY_S_INF = 1'b1; PRDATA = 32'h1234_5678; PSLVERR_S_INF = 1'b1;
        nc(); nc();
        smp();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b exp 0000", req_ready); end
        checks++; if ({PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF, rsp_valid, rsp_err, rsp_timeout} !== 6'b0)
            begin errors++; $display("FAIL rst_ctl: got %b exp 000000", {PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF, rsp_valid, rsp_err, rsp_timeout}); end
        checks++; if ({PADDR_M_INF, PWDATA_M_INF, rsp_rdata, rsp_id} !== 98'b0)
            begin errors++; $display("FAIL rst_data: got %h %h %h %h exp 0", PADDR_M_INF, PWDATA_M_INF, rsp_rdata, rsp_id); end
        nc();
        PRESET_N = 1'b1; req_valid = '0; PSLVERR_S_INF = 1'b0;
        smp();
        checks++; if ({PSEL_M_INF, rsp_valid, req_ready} !== 6'b0)
            begin errors++; $display("FAIL rst_release: got %b exp 000000", {PSEL_M_INF, rsp_valid, req_ready}); end
    endtask

    task automatic test_fairness();
        logic [3:0] er;
        logic [1:0] epe;
        nc();
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b1, 32'h0000_0104, 32'hA5A5_0001);
        PREADY_S_INF = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) nc();
            smp();
            er  = (c % 2 == 0) ? oh((c / 2) % 2) : 4'b0000;
            epe = (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b10 : 2'b11);
            checks++; if (req_ready !== er) begin errors++; $display("FAIL fair_ready c%0d: got %b exp %b", c, req_ready, er); end
            checks++; if ({PSEL_M_INF, PENABLE_M_INF} !== epe) begin errors++; $display("FAIL fair_phase c%0d: got %b exp %b", c, {PSEL_M_INF, PENABLE_M_INF}, epe); end
            checks++; if (rsp_valid !== (c >= 3 && c % 2 == 1)) begin errors++; $display("FAIL fair_rsp c%0d: got %b", c, rsp_valid); end
            if (c >= 3 && c % 2 == 1) begin
                checks++; if (rsp_id !== 2'(((c - 3) / 2) % 2)) begin errors++; $display("FAIL fair_id c%0d: got %0d exp %0d", c, rsp_id, ((c - 3) / 2) % 2); end
            end
        end
        drain(3);
    endtask

    task automatic test_single_read();
        nc();
        req_valid = '0;
        set_req(0, 1'b0, 32'h0000_1000, 32'h0);
        PREADY_S_INF = 1'b1; PRDATA = $urandom; PSLVERR_S_INF = 1'b0;
        smp();
        checks++; if ({req_ready, PSEL_M_INF} !== 5'b00010) begin errors++; $display("FAIL rd_accept: got %b exp 00010", {req_ready, PSEL_M_INF}); end
        nc(); req_valid = '0; PRDATA = $urandom;
        smp();
        checks++; if ({PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF} !== 3'b100 || PADDR_M_INF !== 32'h1000)
            begin errors++; $display("FAIL rd_setup: got %b %h exp 100 1000", {PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF}, PADDR_M_INF); end
        nc(); PRDATA = 32'hDEAD_BEEF;
        smp();
        checks++; if ({PSEL_M_INF, PENABLE_M_INF, rsp_valid} !== 3'b110) begin errors++; $display("FAIL rd_access: got %b exp 110", {PSEL_M_INF, PENABLE_M_INF, rsp_valid}); end
        nc(); PRDATA = $urandom;
        smp();
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_timeout, PSEL_M_INF} !== 6'b100000 || rsp_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL rd_rsp: got %b %h exp 100000 deadbeef", {rsp_valid, rsp_id, rsp_err, rsp_timeout, PSEL_M_INF}, rsp_rdata); end
        nc();
        smp();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got %b %h exp 0 deadbeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_wait_err();
        nc();
        set_req(3, 1'b1, 32'h0000_2000, 32'h5);
        PREADY_S_INF = 1'b0; PSLVERR_S_INF = 1'b0;
        smp();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL we_accept: got %b exp 1000", req_ready); end
        nc();
        req_valid = '0; req_addr[96 +: 32] = 32'hFFFF_FFFF; req_wdata[96 +: 32] = 32'hFFFF_FFFF;
        smp();
        checks++; if ({PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF} !== 3'b101 || PADDR_M_INF !== 32'h2000 || PWDATA_M_INF !== 32'h5)
            begin errors++; $display("FAIL we_setup: got %b %h %h", {PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF}, PADDR_M_INF, PWDATA_M_INF); end
        for (int k = 0; k < 4; k++) begin
            nc();
            PREADY_S_INF = (k == 3); PSLVERR_S_INF = (k == 3); PRDATA = $urandom | 32'h1;
            smp();
            checks++; if ({PSEL_M_INF, PENABLE_M_INF, rsp_valid, req_ready} !== 7'b1100000 || PWDATA_M_INF !== 32'h5 || PADDR_M_INF !== 32'h2000)
                begin errors++; $display("FAIL we_access k%0d: got %b %h %h", k, {PSEL_M_INF, PENABLE_M_INF, rsp_valid, req_ready}, PWDATA_M_INF, PADDR_M_INF); end
        end
        nc(); PREADY_S_INF = 1'b0; PSLVERR_S_INF = 1'b0;
        smp();
        checks++; if ({PSEL_M_INF, rsp_valid, rsp_id, rsp_err, rsp_timeout} !== 6'b011110 || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL we_rsp: got %b %h exp 011110 0", {PSEL_M_INF, rsp_valid, rsp_id, rsp_err, rsp_timeout}, rsp_rdata); end
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        nc();
        set_req(0, 1'b0, 32'h0000_3000, 32'h0);
        PREADY_S_INF = 1'b0; PSLVERR_S_INF = 1'b0;
        smp();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_accept: got %b exp 0001", req_ready); end
        nc(); req_valid = '0;
        smp();
        for (int k = 0; k < TO; k++) begin
            nc();
            if (k == 0) set_req(1, 1'b0, 32'h0000_3100, 32'h0);
            PRDATA = $urandom;
            smp();
            checks++; if (req_ready !== ((k == TO - 1) ? 4'b0010 : 4'b0000) || {PSEL_M_INF, PENABLE_M_INF} !== 2'b11)
                begin errors++; $display("FAIL to_access k%0d: got %b %b", k, req_ready, {PSEL_M_INF, PENABLE_M_INF}); end
        end
        nc(); req_valid = '0; PREADY_S_INF = 1'b1;
        smp();
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_timeout} !== 5'b10011 || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL to_rsp: got %b %h exp 10011 0", {rsp_valid, rsp_id, rsp_err, rsp_timeout}, rsp_rdata); end
        checks++; if ({PSEL_M_INF, PENABLE_M_INF} !== 2'b10 || PADDR_M_INF !== 32'h3100)
            begin errors++; $display("FAIL to_next_setup: got %b %h exp 10 3100", {PSEL_M_INF, PENABLE_M_INF}, PADDR_M_INF); end
        nc(); r = $urandom; PRDATA = r;
        smp();
        nc(); PRDATA = ~r;
        smp();
        checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_timeout} !== 5'b10100 || rsp_rdata !== r)
            begin errors++; $display("FAIL to_next_rsp: got %b %h exp 10100 %h", {rsp_valid, rsp_id, rsp_err, rsp_timeout}, rsp_rdata, r); end
    endtask

    task automatic test_wrap();
        nc();
        set_req(3, 1'b0, 32'h0000_4000, 32'h0);
        PREADY_S_INF = 1'b1;
        smp();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_pre: got %b exp 1000", req_ready); end
        nc(); req_valid = '0;
        nc();
        nc();
        set_req(2, 1'b1, 32'h0000_4200, 32'h22);
        set_req(0, 1'b1, 32'h0000_4000, 32'h11);
        smp();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b exp 0001", req_ready); end
        nc(); req_valid[0] = 1'b0;
        smp();
        checks++; if (req_ready !== 4'b0000 || PADDR_M_INF !== 32'h4000) begin errors++; $display("FAIL wrap_setup: got %b %h", req_ready, PADDR_M_INF); end
        nc();
        smp();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_second: got %b exp 0100", req_ready); end
        nc(); req_valid = '0;
        smp();
        checks++; if ({rsp_valid, rsp_id} !== 3'b100 || PADDR_M_INF !== 32'h4200 || PWDATA_M_INF !== 32'h22)
            begin errors++; $display("FAIL wrap_rsp: got %b %h %h", {rsp_valid, rsp_id}, PADDR_M_INF, PWDATA_M_INF); end
        drain(3);
    endtask

    task automatic test_reset_mid();
        nc();
        set_req(1, 1'b0, 32'h0000_5000, 32'h0);
        PREADY_S_INF = 1'b0;
        smp();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_accept: got %b exp 0010", req_ready); end
        nc(); req_valid = '0;
        nc(); PRESET_N = 1'b0;
        smp();
        checks++; if ({PSEL_M_INF, PENABLE_M_INF} !== 2'b11) begin errors++; $display("FAIL rm_access: got %b exp 11", {PSEL_M_INF, PENABLE_M_INF}); end
        nc(); PRESET_N = 1'b1;
        smp();
        checks++; if ({PSEL_M_INF, PENABLE_M_INF, PWRITE_M_INF, rsp_valid, rsp_err, rsp_timeout, req_ready} !== 10'b0
                      || {PADDR_M_INF, PWDATA_M_INF, rsp_rdata, rsp_id} !== 98'b0)
            begin errors++; $display("FAIL rm_zero: got %b %h %h %h %h", {PSEL_M_INF, PENABLE_M_INF, rsp_valid, req_ready}, PADDR_M_INF, PWDATA_M_INF, rsp_rdata, rsp_id); end
        for (int k = 0; k < 3; k++) begin
            nc(); PREADY_S_INF = 1'b1;
            smp();
            checks++; if ({rsp_valid, PSEL_M_INF} !== 2'b00) begin errors++; $display("FAIL rm_quiet k%0d: got %b exp 00", k, {rsp_valid, PSEL_M_INF}); end
        end
        nc();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h6000 + 32'(i), 32'h0);
        smp();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_priority: got %b exp 0001", req_ready); end
        drain(4);
    endtask

    task automatic test_random();
        int off, len, cw, cid, win, mlast, j;
        logic busy, rsp_due, completing, slot, cwr, e_err, e_to, to;
        logic [31:0] ca, cd, e_rd;
        logic [1:0] e_id;
        logic [3:0] er;
        busy = 0; rsp_due = 0; mlast = NR - 1; off = 0; len = 0; cw = 0; cid = 0; cwr = 0;
        ca = '0; cd = '0; e_rd = '0; e_id = '0; e_err = 0; e_to = 0;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        nc(); PRESET_N = 1'b0; req_valid = '0;
        for (int n = 0; n < 400; n++) begin
            nc();
            PRESET_N = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, (n % 200 < 100) ? 2 : 12) == 0) begin
                    pv[i] = 1'b1; pw[i] = 1'($urandom_range(0, 1)); pa[i] = $urandom; pd[i] = $urandom;
                end
            end
            if (busy) off++;
            completing = busy && (off == 1 + len);
            slot = !busy || completing;
            win = -1;
            if (slot) begin
                for (int k = 1; k <= NR; k++) begin
                    j = (mlast + k) % NR;
                    if (win < 0 && pv[j]) win = j;
                end
            end
            er = (win >= 0) ? oh(win) : 4'b0000;
            if (busy && off >= 2) PREADY_S_INF = (off - 2 == cw);
            else PREADY_S_INF = 1'($urandom_range(0, 1));
            PRDATA = $urandom; PSLVERR_S_INF = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = pv[i]; req_write[i] = pw[i];
                req_addr[i*32 +: 32] = pa[i]; req_wdata[i*32 +: 32] = pd[i];
            end
            smp();
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rnd_ready n%0d: got %b exp %b", n, req_ready, er); end
            checks++; if ({PSEL_M_INF, PENABLE_M_INF} !== {busy, busy && off >= 2})
                begin errors++; $display("FAIL rnd_phase n%0d: got %b exp %b", n, {PSEL_M_INF, PENABLE_M_INF}, {busy, busy && off >= 2}); end
            checks++; if (PADDR_M_INF !== (busy ? ca : 32'h0) || PWRITE_M_INF !== (busy && cwr) || PWDATA_M_INF !== ((busy && cwr) ? cd : 32'h0))
                begin errors++; $display("FAIL rnd_bus n%0d: got %h %b %h", n, PADDR_M_INF, PWRITE_M_INF, PWDATA_M_INF); end
            checks++; if (rsp_valid !== rsp_due) begin errors++; $display("FAIL rnd_rsp_valid n%0d: got %b exp %b", n, rsp_valid, rsp_due); end
            if (rsp_due) begin
                checks++; if ({rsp_id, rsp_err, rsp_timeout} !== {e_id, e_err, e_to} || rsp_rdata !== e_rd)
                    begin errors++; $display("FAIL rnd_rsp n%0d: got %b %h exp %b %h", n, {rsp_id, rsp_err, rsp_timeout}, rsp_rdata, {e_id, e_err, e_to}, e_rd); end
            end
            rsp_due = completing;
            if (completing) begin
                to    = (cw >= TO);
                e_id  = 2'(cid);
                e_rd  = (!cwr && !to) ? PRDATA : 32'h0;
                e_err = PSLVERR_S_INF | to;
                e_to  = to;
                busy  = 1'b0;
            end
            if (win >= 0) begin
                pv[win] = 1'b0;
                cid = win; cwr = pw[win]; ca = pa[win]; cd = pd[win];
                cw  = $urandom_range(0, 6);
                len = (cw < TO) ? cw + 1 : TO;
                busy = 1'b1; off = 0; mlast = win;
            end
        end
        drain(10);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_wait_err();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
